// File: rtl/fractal_pkg.sv
// Shared register map, controller states and parameter-set layout for the fractal frame controller.
package fractal_pkg;

  localparam int unsigned CfgAddrW = 4;

  localparam logic [CfgAddrW-1:0] ADDR_WIDTH  = 4'd0;
  localparam logic [CfgAddrW-1:0] ADDR_HEIGHT = 4'd1;
  localparam logic [CfgAddrW-1:0] ADDR_CR     = 4'd2;
  localparam logic [CfgAddrW-1:0] ADDR_CI     = 4'd3;
  localparam logic [CfgAddrW-1:0] ADDR_DX     = 4'd4;
  localparam logic [CfgAddrW-1:0] ADDR_DY     = 4'd5;
  localparam logic [CfgAddrW-1:0] ADDR_X0     = 4'd6;
  localparam logic [CfgAddrW-1:0] ADDR_Y0     = 4'd7;
  localparam logic [CfgAddrW-1:0] ADDR_DCR    = 4'd8;
  localparam logic [CfgAddrW-1:0] ADDR_DCI    = 4'd9;
  localparam logic [CfgAddrW-1:0] ADDR_CTRL   = 4'd10;

  typedef enum logic [1:0] {
    INIT,
    GEN_RESET,
    RUN
  } ctrl_state_t;

  // Geometry plus Q4.28 view parameters; same layout for shadow and live sets.
  typedef struct packed {
    logic [15:0] width;
    logic [15:0] height;
    logic [31:0] cr;
    logic [31:0] ci;
    logic [31:0] dx;
    logic [31:0] dy;
    logic [31:0] x0;
    logic [31:0] y0;
  } fractal_params_t;

endpackage

// File: rtl/fractal_frame_tracker.sv
// Tracks output lines of the generator, flags frame boundaries and resynchronises on misaligned frame starts.
module fractal_frame_tracker
  import fractal_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        run,
  input  logic [15:0] height,
  input  logic        data_enable,
  input  logic        frame_start,
  input  logic        line_end,
  output logic        boundary_c,
  output logic        sync_error
);

  logic [15:0] line_cnt;
  logic        line_done_c;
  logic        resync_c;

  assign line_done_c = run && data_enable && line_end;
  // A frame start that is not on line 0 wins over a coincident boundary.
  assign resync_c    = run && data_enable && frame_start && (line_cnt != 16'd0);
  assign boundary_c  = line_done_c && !resync_c && (line_cnt == (height - 16'd1));

  // Line counter with wrap at the frame boundary, forced to 0 while the generator is held in reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      line_cnt   <= 16'd0;
      sync_error <= 1'b0;
    end else if (!run) begin
      line_cnt <= 16'd0;
    end else if (resync_c) begin
      line_cnt   <= 16'd0;
      sync_error <= 1'b1;
    end else if (boundary_c) begin
      line_cnt <= 16'd0;
    end else if (line_done_c) begin
      line_cnt <= line_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/fractal_frame_controller.sv
// Shadow/live parameter sequencer for fractal_generator: frame-aligned commits, geometry resets and c animation.
module fractal_frame_controller
  import fractal_pkg::*;
#(
  parameter int unsigned RESET_CYCLES   = 4,
  parameter int unsigned DEFAULT_WIDTH  = 1920,
  parameter int unsigned DEFAULT_HEIGHT = 1080
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                cfg_valid,
  input  logic [CfgAddrW-1:0] cfg_addr,
  input  logic [31:0]         cfg_data,
  input  logic                cfg_commit,
  input  logic                gen_data_enable,
  input  logic                gen_frame_start,
  input  logic                gen_line_end,
  output logic                gen_resetn,
  output logic [15:0]         width,
  output logic [15:0]         height,
  output logic [31:0]         cr,
  output logic [31:0]         ci,
  output logic [31:0]         dx,
  output logic [31:0]         dy,
  output logic [31:0]         x0,
  output logic [31:0]         y0,
  output logic                commit_pending,
  output logic [31:0]         frame_count,
  output logic                sync_error
);

  localparam int unsigned RstCntW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  localparam fractal_params_t DefaultParams = '{
    width:  16'(DEFAULT_WIDTH),
    height: 16'(DEFAULT_HEIGHT),
    cr:     32'd0,
    ci:     32'd0,
    dx:     32'd0,
    dy:     32'd0,
    x0:     32'd0,
    y0:     32'd0
  };

  ctrl_state_t         state;
  fractal_params_t     shadow;
  fractal_params_t     live;
  logic [31:0]         dcr;
  logic [31:0]         dci;
  logic                anim;
  logic [RstCntW-1:0]  rst_cnt;
  logic                boundary_c;
  logic                geom_change_c;

  assign geom_change_c = (shadow.width != live.width) || (shadow.height != live.height);

  fractal_frame_tracker u_tracker (
    .clk         (clk),
    .resetn      (resetn),
    .run         (state == RUN),
    .height      (live.height),
    .data_enable (gen_data_enable),
    .frame_start (gen_frame_start),
    .line_end    (gen_line_end),
    .boundary_c  (boundary_c),
    .sync_error  (sync_error)
  );

  // Register writes, commit bookkeeping and the INIT/GEN_RESET/RUN sequencer.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state          <= INIT;
      gen_resetn     <= 1'b0;
      shadow         <= DefaultParams;
      live           <= DefaultParams;
      dcr            <= 32'd0;
      dci            <= 32'd0;
      anim           <= 1'b0;
      rst_cnt        <= '0;
      commit_pending <= 1'b0;
      frame_count    <= 32'd0;
    end else begin
      if (cfg_valid) begin
        case (cfg_addr)
          ADDR_WIDTH:  shadow.width  <= cfg_data[15:0];
          ADDR_HEIGHT: shadow.height <= cfg_data[15:0];
          ADDR_CR:     shadow.cr     <= cfg_data;
          ADDR_CI:     shadow.ci     <= cfg_data;
          ADDR_DX:     shadow.dx     <= cfg_data;
          ADDR_DY:     shadow.dy     <= cfg_data;
          ADDR_X0:     shadow.x0     <= cfg_data;
          ADDR_Y0:     shadow.y0     <= cfg_data;
          ADDR_DCR:    dcr           <= cfg_data;
          ADDR_DCI:    dci           <= cfg_data;
          ADDR_CTRL:   anim          <= cfg_data[0];
          default:     ;
        endcase
      end

      if (cfg_commit) begin
        commit_pending <= 1'b1;
      end

      case (state)
        INIT: begin
          shadow         <= DefaultParams;
          live           <= DefaultParams;
          commit_pending <= 1'b0;
          gen_resetn     <= 1'b0;
          rst_cnt        <= '0;
          state          <= GEN_RESET;
        end
        GEN_RESET: begin
          if (rst_cnt == RstCntW'(RESET_CYCLES - 1)) begin
            gen_resetn <= 1'b1;
            state      <= RUN;
          end else begin
            rst_cnt <= rst_cnt + RstCntW'(1);
          end
        end
        RUN: begin
          if (boundary_c) begin
            frame_count <= frame_count + 32'd1;
            if (commit_pending) begin
              // Shadow is sampled here, so a commit or write landing on this cycle waits for the next boundary.
              live           <= shadow;
              commit_pending <= 1'b0;
              if (geom_change_c) begin
                gen_resetn <= 1'b0;
                rst_cnt    <= '0;
                state      <= GEN_RESET;
              end
            end else if (anim) begin
              live.cr <= live.cr + dcr;
              live.ci <= live.ci + dci;
            end
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  assign width  = live.width;
  assign height = live.height;
  assign cr     = live.cr;
  assign ci     = live.ci;
  assign dx     = live.dx;
  assign dy     = live.dy;
  assign x0     = live.x0;
  assign y0     = live.y0;

endmodule

// File: doc/fractal_frame_controller.md
# fractal_frame_controller

Sequences and configures `fractal_generator`. Holds a shadow register set written by the host and owns the generator's parameter inputs and its reset. It applies new parameters only at output frame boundaries and resets the generator when the frame geometry changes. It can also animate the Julia constant `c` by a per-frame increment, which gives continuous zoom and morph effects without host traffic per frame.

## Interface
Parameters:
- `RESET_CYCLES`, 4: cycles `gen_resetn` is held low per generator reset (≥1).
- `DEFAULT_WIDTH`, 1920: width after reset.
- `DEFAULT_HEIGHT`, 1080: height after reset.

Ports:
- `clk` in 1: clock.
- `resetn` in 1: reset, synchronous, active-low.
- `cfg_valid` in 1: register write strobe. Always accepted; there is no ready.
- `cfg_addr` in 4: register index.
- `cfg_data` in 32: write data.
- `cfg_commit` in 1: request to apply the shadow set at the next frame boundary.
- `gen_data_enable`, `gen_frame_start`, `gen_line_end` in 1 each: generator tvalid/tuser/tlast, observed only.
- `gen_resetn` out 1: generator reset, active-low.
- `width`, `height` out 16: live geometry.
- `cr`, `ci`, `dx`, `dy`, `x0`, `y0` out 32: live parameters, Q4.28.
- `commit_pending` out 1: a commit is waiting for a boundary.
- `frame_count` out 32: completed output frames.
- `sync_error` out 1: sticky; set on frame misalignment.

## Operation
- Register map (shadow set):
  - 0 width[15:0], 1 height[15:0].
  - 2 cr, 3 ci, 4 dx, 5 dy, 6 x0, 7 y0.
  - 8 dcr, 9 dci: per-frame increments.
  - 10 ctrl: bit0 = anim.
  - Addresses 11–15 are ignored.
- Ctrl, dcr and dci take effect immediately. All other registers reach the outputs only through a commit.
- Frame boundary = cycle with `gen_data_enable && gen_line_end && line_cnt == height-1`.
  - `line_cnt` increments on each `gen_data_enable && gen_line_end` and wraps to 0 at the boundary.
- At a boundary, the controller does the following:
  - `frame_count` += 1 (wraps mod 2^32).
  - If `commit_pending`: copy the shadow registers 0–7 into the live registers and clear `commit_pending`.
    - If the new width or height differs from the live value, go to GEN_RESET.
  - Otherwise, if anim=1: `cr += dcr`, `ci += dci`, both modulo 2^32.
  - A commit suppresses animation for that boundary.
- States:
  - INIT (one cycle after reset): live = shadow = defaults, with all 32-bit registers 0. Go to GEN_RESET.
  - GEN_RESET: `gen_resetn`=0 for `RESET_CYCLES` cycles, `line_cnt`=0, strobes ignored. Then go to RUN.
  - RUN: `gen_resetn`=1. Boundary tracking and commits are active.
- Resync: `gen_frame_start && gen_data_enable` with `line_cnt != 0` forces `line_cnt`=0 and sets `sync_error`.
  - No `frame_count` increment. Only `resetn` clears `sync_error`.
- Simultaneous events:
  - A write in the same cycle as `cfg_commit` is part of the committed set.
  - A write while a commit is pending lands in the shadow set and is applied at that boundary. The shadow set is sampled at the boundary, not at commit time.
  - A commit while a commit is pending is a no-op.
  - A commit in the same cycle as a boundary is applied at the following boundary.
  - A write in the same cycle as a boundary does not take part in that boundary.
- A commit with unchanged geometry applies parameters without resetting the generator.

## Timing
- Reset values of outputs:
  - `gen_resetn`=0, `width`=`DEFAULT_WIDTH`, `height`=`DEFAULT_HEIGHT`.
  - Other parameter outputs 0.
  - `commit_pending`=0, `frame_count`=0, `sync_error`=0.
- First `gen_resetn`=1 occurs `RESET_CYCLES`+1 cycles after `resetn` rises.
- `commit_pending` rises the cycle after `cfg_commit`.
- Live outputs change only on the cycle after a boundary and are otherwise stable. Anim and commit updates both have 1-cycle latency.
- A geometry change drops `gen_resetn` the cycle after the boundary, for exactly `RESET_CYCLES` cycles.
- `resetn` low mid-frame aborts everything: pending commits are lost and the controller returns to INIT/defaults.

## Structure
- `fractal_pkg` holds:
  - register address constants;
  - state enum {INIT, GEN_RESET, RUN};
  - `fractal_params_t` packed struct (width, height, cr, ci, dx, dy, x0, y0), used for both the shadow and live sets.
- Sub-module `fractal_frame_tracker`: `line_cnt`, boundary strobe, resync, `sync_error`.

## Test plan
- Reset release → `gen_resetn` low 4 cycles, then high; outputs are 1920/1080/0.
- Write cr=0x0800_0000, then commit mid-frame → `cr` unchanged until the boundary, becomes 0x0800_0000 the cycle after it; `commit_pending` 1→0; `gen_resetn` stays high.
- Write width=640, height=480, then commit → after the boundary, `gen_resetn` low for 4 cycles; `width`/`height`=640/480; next boundary after 480 lines.
- anim=1, dcr=1, cr=0xFFFF_FFFF → after one boundary `cr`=0 (wrap); `frame_count` +1 per boundary; a commit boundary applies the shadow cr without the increment.
- Height=4; `gen_frame_start` arrives at `line_cnt`=2 → `sync_error`=1, `line_cnt`=0; next boundary after 4 more lines.
- `cfg_commit` in the same cycle as a boundary → not applied there; applied at the following boundary.
